// File: rtl/axil_led_regs_if.sv
// rtl/axil_led_regs_if.sv - AXI4-lite bus bundle for the LED register block
interface axil_led_regs_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_led_regs.sv
// rtl/axil_led_regs.sv - AXI4-lite LED register file with blink engine
// Optional macro AXIL_LED_SLVERR_EN: SLVERR on unmapped accesses and RO writes.
module axil_led_regs #(
   parameter int          DATA_WIDTH     = 32,
   parameter int          ADDR_WIDTH     = 16,
   parameter int          STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int          LED_WIDTH      = 8,
   parameter logic [31:0] ID_VALUE       = 32'h4C45_4401,
   parameter logic [31:0] PERIOD_DEFAULT = 32'd50_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   axil_led_regs_if.slave       s_axil,
   output logic [LED_WIDTH-1:0] led_out
);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                  aw_held;
   logic [2:0]            aw_idx_q;
   logic                  w_held;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_WIDTH-1:0] w_strb_q;

   logic [1:0]            ctrl;
   logic [LED_WIDTH-1:0]  led;
   logic [31:0]           period;
   logic [31:0]           scratch;
   logic [31:0]           counter;
   logic                  phase;

   logic                  aw_hs, w_hs, ar_hs, wr_go;
   logic [2:0]            wr_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;
   logic [DATA_WIDTH-1:0] ctrl_merged, led_merged, period_merged, scratch_merged;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic                  wr_err, rd_err, en_rise, period_wr;
   logic                  unused_bits;

   assign unused_bits = ^{s_axil.awprot, s_axil.arprot,
                          s_axil.awaddr[ADDR_WIDTH-1:5], s_axil.awaddr[1:0],
                          s_axil.araddr[ADDR_WIDTH-1:5], s_axil.araddr[1:0]};

   assign s_axil.awready = !rst && !aw_held && !s_axil.bvalid;
   assign s_axil.wready  = !rst && !w_held && !s_axil.bvalid;
   assign s_axil.arready = !rst && !s_axil.rvalid;

   assign aw_hs = s_axil.awvalid && s_axil.awready;
   assign w_hs  = s_axil.wvalid && s_axil.wready;
   assign ar_hs = s_axil.arvalid && s_axil.arready;

   // A write fires once both halves are present, whether held or arriving now.
   assign wr_go   = (aw_held || aw_hs) && (w_held || w_hs);
   assign wr_idx  = aw_held ? aw_idx_q : s_axil.awaddr[4:2];
   assign wr_data = w_held ? w_data_q : s_axil.wdata;
   assign wr_strb = w_held ? w_strb_q : s_axil.wstrb;

   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                   input logic [DATA_WIDTH-1:0] data,
                                                   input logic [STRB_WIDTH-1:0] strb);
      logic [DATA_WIDTH-1:0] res;
      res = old;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
      end
      return res;
   endfunction

   always_comb begin
      ctrl_merged    = merge({30'b0, ctrl}, wr_data, wr_strb);
      led_merged     = merge(DATA_WIDTH'(led), wr_data, wr_strb);
      period_merged  = merge(period, wr_data, wr_strb);
      scratch_merged = merge(scratch, wr_data, wr_strb);
   end

   assign en_rise   = wr_go && (wr_idx == 3'd1) && !ctrl[0] && ctrl_merged[0];
   assign period_wr = wr_go && (wr_idx == 3'd3);

`ifdef AXIL_LED_SLVERR_EN
   assign wr_err = (wr_idx == 3'd0) || (wr_idx >= 3'd5);
   assign rd_err = (s_axil.araddr[4:2] >= 3'd6);
`else
   assign wr_err = 1'b0;
   assign rd_err = 1'b0;
`endif

   always_comb begin
      rd_mux = '0;
      case (s_axil.araddr[4:2])
         3'd0:    rd_mux = ID_VALUE;
         3'd1:    rd_mux = {30'b0, ctrl};
         3'd2:    rd_mux = DATA_WIDTH'(led);
         3'd3:    rd_mux = period;
         3'd4:    rd_mux = scratch;
         3'd5:    rd_mux = {31'b0, phase};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held       <= 1'b0;
         aw_idx_q      <= '0;
         w_held        <= 1'b0;
         w_data_q      <= '0;
         w_strb_q      <= '0;
         s_axil.bvalid <= 1'b0;
         s_axil.bresp  <= RESP_OKAY;
         ctrl          <= '0;
         led           <= '0;
         period        <= PERIOD_DEFAULT;
         scratch       <= '0;
      end else if (wr_go) begin
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         s_axil.bvalid <= 1'b1;
         s_axil.bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
         case (wr_idx)
            3'd1:    ctrl    <= ctrl_merged[1:0];
            3'd2:    led     <= led_merged[LED_WIDTH-1:0];
            3'd3:    period  <= period_merged;
            3'd4:    scratch <= scratch_merged;
            default: ;
         endcase
      end else begin
         if (aw_hs) begin
            aw_held  <= 1'b1;
            aw_idx_q <= s_axil.awaddr[4:2];
         end
         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_axil.wdata;
            w_strb_q <= s_axil.wstrb;
         end
         if (s_axil.bvalid && s_axil.bready) s_axil.bvalid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_axil.rvalid <= 1'b0;
         s_axil.rdata  <= '0;
         s_axil.rresp  <= RESP_OKAY;
      end else if (ar_hs) begin
         s_axil.rvalid <= 1'b1;
         s_axil.rdata  <= rd_mux;
         s_axil.rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axil.rvalid && s_axil.rready) begin
         s_axil.rvalid <= 1'b0;
      end
   end

   // Restarts take priority so a shrinking PERIOD never lets the counter wrap.
   always_ff @(posedge clk) begin
      if (rst || period_wr || en_rise || !ctrl[0] || period == 32'd0) begin
         counter <= '0;
         phase   <= 1'b0;
      end else if (counter == period - 32'd1) begin
         counter <= '0;
         phase   <= !phase;
      end else begin
         counter <= counter + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) led_out <= '0;
      else     led_out <= (phase ? '0 : led) ^ {LED_WIDTH{ctrl[1]}};
   end
endmodule

// File: tb/tb_axil_led_regs.sv
// tb/tb_axil_led_regs.sv - randomized self-checking bench for axil_led_regs
module tb_axil_led_regs;
   localparam logic [31:0] ID_VALUE       = 32'h4C45_4401;
   localparam logic [31:0] PERIOD_DEFAULT = 32'd50_000_000;
`ifdef AXIL_LED_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] led_out;

   axil_led_regs_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

   axil_led_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .LED_WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_axil  (bus),
      .led_out (led_out)
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   logic rst_q = 1'b1;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   // Reference state; blink phase is derived arithmetically from the restart cycle.
   logic [1:0]  m_ctrl;
   logic [7:0]  m_led;
   logic [31:0] m_period;
   logic [31:0] m_scratch;
   longint      m_start;

   function automatic void model_reset();
      m_ctrl = 2'b0; m_led = 8'h0; m_period = PERIOD_DEFAULT; m_scratch = 32'h0; m_start = 0;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] strb);
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++) if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
      return res;
   endfunction

   function automatic void model_write(input logic [15:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb, input int e);
      logic [31:0] nv;
      case (addr[4:2])
         3'd1: begin
            nv = merge({30'b0, m_ctrl}, data, strb);
            if (!m_ctrl[0] && nv[0]) m_start = e;
            m_ctrl = nv[1:0];
         end
         3'd2: begin nv = merge({24'b0, m_led}, data, strb); m_led = nv[7:0]; end
         3'd3: begin m_period = merge(m_period, data, strb); m_start = e; end
         3'd4: m_scratch = merge(m_scratch, data, strb);
         default: ;
      endcase
   endfunction

   function automatic logic phase_at(input int e);
      if (!m_ctrl[0] || m_period == 32'd0) return 1'b0;
      return (((longint'(e) - m_start) / longint'(m_period)) % 2) == 1;
   endfunction

   function automatic logic [7:0] led_src(input int e);
      return (phase_at(e) ? 8'h00 : m_led) ^ {8{m_ctrl[1]}};
   endfunction

   function automatic logic [31:0] model_read(input logic [15:0] addr, input int e);
      case (addr[4:2])
         3'd0:    return ID_VALUE;
         3'd1:    return {30'b0, m_ctrl};
         3'd2:    return {24'b0, m_led};
         3'd3:    return m_period;
         3'd4:    return m_scratch;
         3'd5:    return {31'b0, phase_at(e)};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [1:0] exp_bresp(input logic [15:0] addr);
      return (SLVERR_EN && (addr[4:2] == 3'd0 || addr[4:2] >= 3'd5)) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [1:0] exp_rresp(input logic [15:0] addr);
      return (SLVERR_EN && addr[4:2] >= 3'd6) ? 2'b10 : 2'b00;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   logic [7:0] prev_src = 8'h0;
   always @(negedge clk) begin
      if (rst_q) check("led_reset", 32'(led_out), 32'h0);
      else       check("led_out", 32'(led_out), 32'(prev_src));
      prev_src <= led_src(cyc);
   end

   logic [1:0] last_bresp;

   task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly);
      bit aw_done = 0, w_done = 0, aw_fire, w_fire;
      int n = 0;
      while (!(aw_done && w_done) && n < 64) begin
         if (!aw_done && n >= aw_dly) begin bus.awaddr = addr; bus.awvalid = 1'b1; end
         if (!w_done && n >= w_dly) begin
            bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
         end
         @(negedge clk);
         check("bvalid_idle", 32'(bus.bvalid), 32'h0);
         aw_fire = bus.awvalid && bus.awready;
         w_fire  = bus.wvalid && bus.wready;
         @(posedge clk); #1;
         if (aw_fire) begin aw_done = 1; bus.awvalid = 1'b0; end
         if (w_fire)  begin w_done = 1;  bus.wvalid = 1'b0; end
         n++;
      end
      if (!(aw_done && w_done)) begin
         check("write_timeout", 32'h0, 32'h1);
         bus.awvalid = 1'b0; bus.wvalid = 1'b0;
         return;
      end
      model_write(addr, data, strb, cyc);
      @(negedge clk);
      check("bvalid_lat", 32'(bus.bvalid), 32'h1);
      check("bresp", 32'(bus.bresp), 32'(exp_bresp(addr)));
      last_bresp = bus.bresp;
      for (int i = 0; i < b_dly; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("bvalid_hold", 32'(bus.bvalid), 32'h1);
         check("awready_blocked", 32'(bus.awready), 32'h0);
         check("wready_blocked", 32'(bus.wready), 32'h0);
      end
      @(posedge clk); #1; bus.bready = 1'b1;
      @(posedge clk); #1; bus.bready = 1'b0;
      @(negedge clk);
      check("bvalid_clear", 32'(bus.bvalid), 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [15:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
      bit done = 0, fire;
      int n = 0;
      logic [31:0] exp_data = 32'h0;
      data = 32'h0; resp = 2'b0;
      while (!done && n < 64) begin
         if (n >= ar_dly) begin bus.araddr = addr; bus.arvalid = 1'b1; end
         @(negedge clk);
         check("rvalid_idle", 32'(bus.rvalid), 32'h0);
         fire = bus.arvalid && bus.arready;
         if (fire) exp_data = model_read(addr, cyc);
         @(posedge clk); #1;
         if (fire) begin done = 1; bus.arvalid = 1'b0; end
         n++;
      end
      if (!done) begin
         check("read_timeout", 32'h0, 32'h1);
         bus.arvalid = 1'b0;
         return;
      end
      @(negedge clk);
      check("rvalid_lat", 32'(bus.rvalid), 32'h1);
      check("rdata", bus.rdata, exp_data);
      check("rresp", 32'(bus.rresp), 32'(exp_rresp(addr)));
      data = bus.rdata; resp = bus.rresp;
      for (int i = 0; i < r_dly; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("rvalid_hold", 32'(bus.rvalid), 32'h1);
         check("rdata_stable", bus.rdata, exp_data);
         check("arready_blocked", 32'(bus.arready), 32'h0);
      end
      @(posedge clk); #1; bus.rready = 1'b1;
      @(posedge clk); #1; bus.rready = 1'b0;
      @(negedge clk);
      check("rvalid_clear", 32'(bus.rvalid), 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic blink_counts(output int n_ff, output int n_00);
      n_ff = 0; n_00 = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (led_out == 8'hFF) n_ff++;
         if (led_out == 8'h00) n_00++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   logic [31:0] rd;
   logic [1:0]  rr;
   int          n_ff, n_00;

   initial begin
      model_reset();
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

      @(negedge clk);
      check("awready_rst", 32'(bus.awready), 32'h0);
      check("wready_rst", 32'(bus.wready), 32'h0);
      check("arready_rst", 32'(bus.arready), 32'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("bvalid_rst", 32'(bus.bvalid), 32'h0);
      check("rvalid_rst", 32'(bus.rvalid), 32'h0);
      check("rdata_rst", bus.rdata, 32'h0);
      @(posedge clk); #1;

      axi_read(16'h0000, 0, 0, rd, rr);
      check("id_literal", rd, 32'h4C45_4401);
      axi_read(16'h000C, 0, 1, rd, rr);
      check("period_literal", rd, 32'd50_000_000);

      axi_write(16'h0008, 32'h0000_00A5, 4'h1, 0, 4, 5);
      @(negedge clk);
      check("led_a5_literal", 32'(led_out), 32'hA5);
      @(posedge clk); #1;

      axi_write(16'h0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
      axi_write(16'h0010, 32'h0000_1200, 4'h2, 1, 0, 0);
      axi_read(16'h0010, 0, 0, rd, rr);
      check("scratch_strb_literal", rd, 32'hDEAD_12EF);

      axi_write(16'h000C, 32'd4, 4'hF, 0, 0, 0);
      axi_write(16'h0008, 32'hFF, 4'hF, 0, 0, 0);
      axi_write(16'h0004, 32'h1, 4'hF, 0, 0, 0);
      blink_counts(n_ff, n_00);
      check("blink_ff_count", 32'(n_ff), 32'd4);
      check("blink_00_count", 32'(n_00), 32'd4);
      axi_write(16'h0004, 32'h3, 4'hF, 0, 0, 0);
      blink_counts(n_ff, n_00);
      check("blink_inv_ff_count", 32'(n_ff), 32'd4);
      check("blink_inv_00_count", 32'(n_00), 32'd4);
      axi_write(16'h000C, 32'd0, 4'hF, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("steady_inv_literal", 32'(led_out), 32'h00);
      end
      @(posedge clk); #1;
      axi_read(16'h0014, 0, 0, rd, rr);
      check("status_literal", rd, 32'h0);

      fork
         axi_write(16'h0010, 32'h1234_5678, 4'hF, 0, 0, 0);
         axi_read(16'h0010, 0, 0, rd, rr);
      join
      check("same_cycle_old_literal", rd, 32'hDEAD_12EF);
      axi_read(16'hA010, 0, 0, rd, rr);
      check("alias_new_literal", rd, 32'h1234_5678);

      axi_read(16'h0018, 0, 0, rd, rr);
      check("unmapped_rdata_literal", rd, 32'h0);
      check("unmapped_rresp_literal", 32'(rr), SLVERR_EN ? 32'h2 : 32'h0);
      axi_write(16'h0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      check("ro_bresp_literal", 32'(last_bresp), SLVERR_EN ? 32'h2 : 32'h0);
      axi_read(16'h0000, 0, 0, rd, rr);
      check("id_unchanged_literal", rd, 32'h4C45_4401);

      bus.awaddr = 16'h0010; bus.awvalid = 1'b1;
      bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      model_write(16'h0010, 32'h55, 4'hF, cyc);
      @(negedge clk);
      check("bvalid_before_rst", 32'(bus.bvalid), 32'h1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      model_reset();
      rst = 1'b0;
      @(negedge clk);
      check("bvalid_after_rst", 32'(bus.bvalid), 32'h0);
      @(posedge clk); #1;
      axi_read(16'h0010, 0, 0, rd, rr);
      check("scratch_after_rst_literal", rd, 32'h0);
      axi_read(16'h000C, 0, 0, rd, rr);
      check("period_after_rst_literal", rd, 32'd50_000_000);

      for (int it = 0; it < 80; it++) begin
         logic [2:0]  idx;
         logic [15:0] addr;
         logic [31:0] hi, data;
         logic [3:0]  strb;
         int          op;
         op   = $urandom_range(0, 9);
         idx  = 3'($urandom_range(0, 7));
         hi   = $urandom;
         addr = {hi[10:0], idx, 2'b00};
         if (idx == 3'd3) begin
            data = $urandom_range(0, 5);
            strb = 4'hF;
         end else begin
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
         end
         if (op <= 4) begin
            axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2));
         end else if (op <= 8) begin
            axi_read(addr, $urandom_range(0, 2), $urandom_range(0, 2), rd, rr);
         end else begin
            fork
               axi_write(addr, data, strb, 0, 0, $urandom_range(0, 1));
               axi_read({hi[26:16], idx, 2'b00}, 0, $urandom_range(0, 1), rd, rr);
            join
         end
         repeat ($urandom_range(0, 6)) begin
            @(posedge clk); #1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
